checker_mode_dump: RTL and testbench

- Checker mode component that answers the checker control interface's start/end/irq/ack/error handshake.
- When started, it reads QWORDS consecutive 64-bit quad words beginning at mode_addr through a valid/ready memory read port.
- Each quad word is presented on mode_data and announced with mode_irq; the block then waits for mode_ack before fetching the next one.
- It sits between the checker control interface and the PCIe read-request engine.

---
 rtl/checker_mode_dump_if.sv | 32 +++
 rtl/checker_mode_dump.sv | 135 +++++++++++++
 tb/tb_checker_mode_dump.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/checker_mode_dump_if.sv
// Control-interface and read-port signals of the checker mode dump block.
// Latency: none, wiring only.
// Backpressure: rd_ready stalls requests; mode_ack paces quad word delivery.
interface checker_mode_dump_if;
  // control interface side
  logic        mode_start;
  logic [63:0] mode_addr;
  logic        mode_end;
  logic [63:0] mode_data;
  logic        mode_irq;
  logic        mode_ack;
  logic        mode_error;
  // memory read port side
  logic        rd_req;
  logic [63:0] rd_addr;
  logic        rd_ready;
  logic        rd_valid;
  logic [63:0] rd_data;
  logic        rd_err;

  // the dump block drives requests and results
  modport master (
    input  mode_start, mode_addr, mode_ack, rd_ready, rd_valid, rd_data, rd_err,
    output mode_end, mode_data, mode_irq, mode_error, rd_req, rd_addr
  );

  // control interface and memory model
  modport slave (
    output mode_start, mode_addr, mode_ack, rd_ready, rd_valid, rd_data, rd_err,
    input  mode_end, mode_data, mode_irq, mode_error, rd_req, rd_addr
  );
endinterface

// File: rtl/checker_mode_dump.sv
// Reads QWORDS quad words from mode_addr and hands each one to the control interface.
// Latency: mode_irq one cycle after rd_valid; next rd_req one cycle after mode_ack.
// Backpressure: holds rd_req until rd_ready; waits on mode_ack before each next fetch.
module checker_mode_dump #(
  parameter int QWORDS  = 512,
  parameter int TIMEOUT = 1024
) (
  input logic                 sys_clk,
  input logic                 sys_rst,
  checker_mode_dump_if.master bus
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    REQ       = 3'd1,
    WAIT_DATA = 3'd2,
    WAIT_ACK  = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam logic [15:0] LAST_IDX = 16'(QWORDS - 1);
  localparam logic [31:0] TO_LAST  = 32'(TIMEOUT - 1);

  state_t      state;
  logic [15:0] index;
  logic [31:0] tcount;
  logic        mode_end;
  logic        mode_error;
  logic        mode_irq;
  logic [63:0] mode_data;
  logic        rd_req;
  logic [63:0] rd_addr;

  // byte offset within a quad word is meaningless for aligned reads
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^bus.mode_addr[2:0];

  assign bus.mode_end   = mode_end;
  assign bus.mode_error = mode_error;
  assign bus.mode_irq   = mode_irq;
  assign bus.mode_data  = mode_data;
  assign bus.rd_req     = rd_req;
  assign bus.rd_addr    = rd_addr;

  // Run sequencer: request, await response, hand over, await ack, repeat.
  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= IDLE;
      index      <= '0;
      tcount     <= '0;
      mode_end   <= 1'b0;
      mode_error <= 1'b0;
      mode_irq   <= 1'b0;
      mode_data  <= '0;
      rd_req     <= 1'b0;
      rd_addr    <= '0;
    end else begin
      // end/error are single-cycle pulses
      mode_end   <= 1'b0;
      mode_error <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.mode_start) begin
            index   <= '0;
            rd_addr <= {bus.mode_addr[63:3], 3'b000};
            rd_req  <= 1'b1;
            state   <= REQ;
          end
        end
        REQ: begin
          if (!bus.mode_start) begin
            rd_req   <= 1'b0;
            mode_irq <= 1'b0;
            state    <= IDLE;
          end else if (bus.rd_ready) begin
            rd_req <= 1'b0;
            tcount <= '0;
            state  <= WAIT_DATA;
          end
        end
        WAIT_DATA: begin
          // abort beats error beats timeout beats data
          if (!bus.mode_start) begin
            rd_req   <= 1'b0;
            mode_irq <= 1'b0;
            state    <= IDLE;
          end else if (bus.rd_valid && bus.rd_err) begin
            mode_error <= 1'b1;
            state      <= DONE;
          end else if ((TIMEOUT != 0) && (tcount == TO_LAST)) begin
            mode_error <= 1'b1;
            state      <= DONE;
          end else if (bus.rd_valid) begin
            mode_data <= bus.rd_data;
            mode_irq  <= 1'b1;
            state     <= WAIT_ACK;
          end else begin
            tcount <= tcount + 32'd1;
          end
        end
        WAIT_ACK: begin
          if (!bus.mode_start) begin
            rd_req   <= 1'b0;
            mode_irq <= 1'b0;
            state    <= IDLE;
          end else if (bus.mode_ack) begin
            // cleared on the ack edge so the control side samples it low
            mode_irq <= 1'b0;
            if (index == LAST_IDX) begin
              mode_end <= 1'b1;
              state    <= DONE;
            end else begin
              index   <= index + 16'd1;
              rd_addr <= rd_addr + 64'd8;
              rd_req  <= 1'b1;
              state   <= REQ;
            end
          end
        end
        DONE: begin
          // no restart until the control side has released start
          if (!bus.mode_start) begin
            state <= IDLE;
          end
        end
        default: begin
          rd_req   <= 1'b0;
          mode_irq <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_checker_mode_dump.sv
// Directed bench for checker_mode_dump with QWORDS=2 and TIMEOUT=16.
// Latency: expectations are the registered outputs just after each clock edge.
// Backpressure: rd_ready and mode_ack are driven per vector.
module tb_checker_mode_dump;

  logic sys_clk;
  logic sys_rst;

  checker_mode_dump_if bus ();

  checker_mode_dump #(.QWORDS(2), .TIMEOUT(16)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .bus     (bus.master)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  localparam logic [63:0] D1 = 64'hA5A5_0001_DEAD_BEEF;
  localparam logic [63:0] D2 = 64'h5A5A_0002_CAFE_F00D;
  localparam logic [63:0] D3 = 64'h1234_5678_9ABC_DEF0;
  localparam logic [63:0] D4 = 64'h0F0F_F0F0_0F0F_F0F0;
  localparam logic [63:0] D5 = 64'h8000_0000_0000_0001;
  localparam logic [63:0] JUNK = 64'hBAD0_BAD0_BAD0_BAD0;

  typedef struct {
    logic        st;
    logic [63:0] ad;
    logic        ack;
    logic        rdy;
    logic        vld;
    logic [63:0] dat;
    logic        err;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_irq;
    logic [63:0] e_data;
    logic        e_end;
    logic        e_err;
  } vec_t;

  vec_t vq[$];
  int   total;
  int   passed;

  task automatic add(input logic st, input logic [63:0] ad, input logic ack,
                     input logic rdy, input logic vld, input logic [63:0] dat,
                     input logic err, input logic e_req, input logic [63:0] e_addr,
                     input logic e_irq, input logic [63:0] e_data,
                     input logic e_end, input logic e_err);
    vec_t v;
    v.st = st; v.ad = ad; v.ack = ack; v.rdy = rdy; v.vld = vld;
    v.dat = dat; v.err = err; v.e_req = e_req; v.e_addr = e_addr;
    v.e_irq = e_irq; v.e_data = e_data; v.e_end = e_end; v.e_err = e_err;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
  endtask

  task automatic chk_all(input int idx, input logic e_req, input logic [63:0] e_addr,
                         input logic e_irq, input logic [63:0] e_data,
                         input logic e_end, input logic e_err);
    chk("rd_req", idx, 64'(bus.rd_req), 64'(e_req));
    chk("rd_addr", idx, bus.rd_addr, e_addr);
    chk("mode_irq", idx, 64'(bus.mode_irq), 64'(e_irq));
    chk("mode_data", idx, bus.mode_data, e_data);
    chk("mode_end", idx, 64'(bus.mode_end), 64'(e_end));
    chk("mode_error", idx, 64'(bus.mode_error), 64'(e_err));
  endtask

  task automatic drive(input logic st, input logic [63:0] ad, input logic ack,
                       input logic rdy, input logic vld, input logic [63:0] dat,
                       input logic err);
    bus.mode_start = st; bus.mode_addr = ad; bus.mode_ack = ack;
    bus.rd_ready = rdy; bus.rd_valid = vld; bus.rd_data = dat; bus.rd_err = err;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    sys_rst = 1'b0;
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);

    // two quad words from an unaligned base, one-cycle memory
    add(1, 64'h1000_0005, 0, 0, 0, 0,    0, 1, 64'h1000_0000, 0, 0,  0, 0);
    add(1, 64'h1000_0005, 0, 1, 0, 0,    0, 0, 64'h1000_0000, 0, 0,  0, 0);
    add(1, 64'h1000_0005, 0, 0, 1, D1,   0, 0, 64'h1000_0000, 1, D1, 0, 0);
    add(1, 64'h1000_0005, 0, 0, 0, 0,    0, 0, 64'h1000_0000, 1, D1, 0, 0);
    add(1, 64'h1000_0005, 1, 0, 0, 0,    0, 1, 64'h1000_0008, 0, D1, 0, 0);
    add(1, 64'h1000_0005, 0, 1, 0, 0,    0, 0, 64'h1000_0008, 0, D1, 0, 0);
    add(1, 64'h1000_0005, 0, 0, 1, D2,   0, 0, 64'h1000_0008, 1, D2, 0, 0);
    add(1, 64'h1000_0005, 1, 0, 0, 0,    0, 0, 64'h1000_0008, 0, D2, 1, 0);
    add(1, 64'h1000_0005, 0, 0, 0, 0,    0, 0, 64'h1000_0008, 0, D2, 0, 0);
    add(1, 64'h1000_0005, 1, 0, 0, 0,    0, 0, 64'h1000_0008, 0, D2, 0, 0);
    add(0, 64'h0,         0, 0, 0, 0,    0, 0, 64'h1000_0008, 0, D2, 0, 0);
    add(0, 64'h0,         0, 0, 1, JUNK, 0, 0, 64'h1000_0008, 0, D2, 0, 0);
    // request stalled five cycles, then a response timeout
    add(1, 64'h2000_0000, 0, 0, 0, 0,    0, 1, 64'h2000_0000, 0, D2, 0, 0);
    add(1, 64'h2000_0000, 0, 0, 0, 0,    0, 1, 64'h2000_0000, 0, D2, 0, 0);
    add(1, 64'h2000_0000, 0, 0, 1, JUNK, 0, 1, 64'h2000_0000, 0, D2, 0, 0);
    add(1, 64'h2000_0000, 0, 0, 0, 0,    0, 1, 64'h2000_0000, 0, D2, 0, 0);
    add(1, 64'h2000_0000, 0, 0, 0, 0,    0, 1, 64'h2000_0000, 0, D2, 0, 0);
    add(1, 64'h2000_0000, 0, 0, 0, 0,    0, 1, 64'h2000_0000, 0, D2, 0, 0);
    add(1, 64'h2000_0000, 0, 1, 0, 0,    0, 0, 64'h2000_0000, 0, D2, 0, 0);
    for (int i = 0; i < 15; i++)
      add(1, 64'h2000_0000, 0, 0, 0, 0,  0, 0, 64'h2000_0000, 0, D2, 0, 0);
    add(1, 64'h2000_0000, 0, 0, 0, 0,    0, 0, 64'h2000_0000, 0, D2, 0, 1);
    add(1, 64'h2000_0000, 0, 0, 0, 0,    0, 0, 64'h2000_0000, 0, D2, 0, 0);
    add(0, 64'h0,         0, 0, 0, 0,    0, 0, 64'h2000_0000, 0, D2, 0, 0);
    // error response
    add(1, 64'h3000_0000, 0, 0, 0, 0,    0, 1, 64'h3000_0000, 0, D2, 0, 0);
    add(1, 64'h3000_0000, 0, 1, 0, 0,    0, 0, 64'h3000_0000, 0, D2, 0, 0);
    add(1, 64'h3000_0000, 0, 0, 1, JUNK, 1, 0, 64'h3000_0000, 0, D2, 0, 1);
    add(1, 64'h3000_0000, 0, 0, 0, 0,    0, 0, 64'h3000_0000, 0, D2, 0, 0);
    add(0, 64'h0,         0, 0, 0, 0,    0, 0, 64'h3000_0000, 0, D2, 0, 0);
    // abort while waiting for ack, then a run that wraps the address
    add(1, 64'h4000_0000, 0, 0, 0, 0,    0, 1, 64'h4000_0000, 0, D2, 0, 0);
    add(1, 64'h4000_0000, 0, 1, 0, 0,    0, 0, 64'h4000_0000, 0, D2, 0, 0);
    add(1, 64'h4000_0000, 0, 0, 1, D3,   0, 0, 64'h4000_0000, 1, D3, 0, 0);
    add(0, 64'h0,         0, 0, 0, 0,    0, 0, 64'h4000_0000, 0, D3, 0, 0);
    add(1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 0, 0,  0, 1, 64'hFFFF_FFFF_FFFF_FFF8, 0, D3, 0, 0);
    add(1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1, 0, 0,  0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 0, D3, 0, 0);
    add(1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, D4, 0, 0, 64'hFFFF_FFFF_FFFF_FFF8, 1, D4, 0, 0);
    add(1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 0, 0,  0, 1, 64'h0, 0, D4, 0, 0);
    add(1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 1, 0, 0,  0, 0, 64'h0, 0, D4, 0, 0);
    add(1, 64'hFFFF_FFFF_FFFF_FFF8, 0, 0, 1, D5, 0, 0, 64'h0, 1, D5, 0, 0);
    add(1, 64'hFFFF_FFFF_FFFF_FFF8, 1, 0, 0, 0,  0, 0, 64'h0, 0, D5, 1, 0);
    add(0, 64'h0,         0, 0, 0, 0,    0, 0, 64'h0,         0, D5, 0, 0);
    // abort while the request is pending
    add(1, 64'h5000_0000, 0, 0, 0, 0,    0, 1, 64'h5000_0000, 0, D5, 0, 0);
    add(0, 64'h0,         0, 0, 0, 0,    0, 0, 64'h5000_0000, 0, D5, 0, 0);

    // reset state
    #3;
    chk_all(-1, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    #9 sys_rst = 1'b1;

    foreach (vq[i]) begin
      drive(vq[i].st, vq[i].ad, vq[i].ack, vq[i].rdy, vq[i].vld, vq[i].dat, vq[i].err);
      @(posedge sys_clk);
      #1;
      chk_all(i, vq[i].e_req, vq[i].e_addr, vq[i].e_irq, vq[i].e_data,
              vq[i].e_end, vq[i].e_err);
    end

    // reset in the middle of WAIT_DATA clears outputs without a clock edge
    drive(1'b1, 64'h6000_0000, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    @(posedge sys_clk); #1;
    chk("rst_seq_req", 100, 64'(bus.rd_req), 64'd1);
    drive(1'b1, 64'h6000_0000, 1'b0, 1'b1, 1'b0, 64'd0, 1'b0);
    @(posedge sys_clk); #1;
    drive(1'b1, 64'h6000_0000, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    chk("rst_seq_addr", 101, bus.rd_addr, 64'h6000_0000);
    #2 sys_rst = 1'b0;
    #1;
    chk_all(102, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b1, JUNK, 1'b0);
    @(posedge sys_clk); #1;
    chk_all(103, 1'b0, 64'd0, 1'b0, 64'd0, 1'b0, 1'b0);
    drive(1'b0, 64'd0, 1'b0, 1'b0, 1'b0, 64'd0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
